// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, frame constants and Hamming(7,4) encoder
//
// Purpose: state codes shared by the UART transmitter and receiver, the number of
//   code bits per frame, and the Hamming(7,4) encoding function.
// Contents:
//   IDLE/START/DATA/STOP  2-bit state codes (00/01/10/11)
//   FRAME_BITS            code bits carried by one frame (7)
//   uart_state_e          FSM state type built on the codes above
//   hamming74_encode      {d4,d3,d2,d1} -> {d4,d3,d2,p3,d1,p2,p1}
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  localparam int FRAME_BITS = 7;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_DATA  = DATA,
    S_STOP  = STOP
  } uart_state_e;

  function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

endpackage

// File: rtl/uart_hamming_transmitter_if.sv
// rtl/uart_hamming_transmitter_if.sv - nibble handshake between a producer and the transmitter
//
// Purpose: groups the valid/ready nibble handshake.
// Signals:
//   data_in     4  nibble {d4,d3,d2,d1}
//   data_valid  1  data_in is valid
//   ready       1  transmitter holding buffer is empty
// Modports: master (producer), slave (transmitter).
interface uart_hamming_transmitter_if;

  logic [3:0] data_in;
  logic       data_valid;
  logic       ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);

endinterface

// File: rtl/hamming74_encoder.sv
// rtl/hamming74_encoder.sv - combinational Hamming(7,4) encoder
//
// Purpose: wraps the package encoding function so it can be instantiated on its own.
// Ports:
//   data_i  in   4  nibble {d4,d3,d2,d1}
//   code_o  out  7  codeword {d4,d3,d2,p3,d1,p2,p1}; code_o[0] is sent first
module hamming74_encoder
  import uart_pkg::*;
(
  input  logic [3:0] data_i,
  output logic [6:0] code_o
);

  assign code_o = hamming74_encode(data_i);

endmodule

// File: rtl/uart_hamming_transmitter.sv
// rtl/uart_hamming_transmitter.sv - Hamming(7,4)-encoding UART frame transmitter
//
// Purpose: accepts nibbles, encodes them into a one-entry holding buffer and sends each
//   codeword as start(0) + 7 code bits LSB first + stop(1), OVERSAMPLE ena cycles per bit.
// Ports:
//   clk        in   1  clock
//   rst        in   1  synchronous active-high reset
//   ena        in   1  cycle enable; all state freezes while low
//   bus        --   -  slave side of the nibble handshake (data_in, data_valid, ready)
//   tx         out  1  registered serial line, idles high
//   busy       out  1  frame in progress or buffer full
//   state_out  out  2  FSM state (00 IDLE, 01 START, 10 DATA, 11 STOP)
module uart_hamming_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  uart_hamming_transmitter_if.slave   bus,
  output logic                        tx,
  output logic                        busy,
  output logic [1:0]                  state_out
);

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(FRAME_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [6:0]        buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              tx_q, tx_d;

  logic [6:0] code;
  logic       accept;

  hamming74_encoder u_enc (
    .data_i (bus.data_in),
    .code_o (code)
  );

  // Accept and drain can never coincide: accept needs an empty buffer, drain a full one.
  assign accept = ena & bus.data_valid & ~buf_full_q;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_d       = tx_q;

    if (ena) begin
      if (accept) begin
        buf_d      = code;
        buf_full_d = 1'b1;
      end

      // tick_d increments everywhere except at IDLE->START; at the last tick it wraps
      // to 0, which is exactly the start of the next bit.
      unique case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            tick_d     = '0;
            state_d    = S_START;
            tx_d       = 1'b0;
          end
        end
        S_START: begin
          tx_d   = 1'b0;
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            tx_d      = shift_q[0];
          end
        end
        S_DATA: begin
          tx_d   = shift_q[0];
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end else begin
              shift_d   = shift_q >> 1;
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_d      = shift_q[1];
            end
          end
        end
        S_STOP: begin
          tx_d   = 1'b1;
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            if (buf_full_q) begin
              // Chain straight into the next frame with no idle gap.
              shift_d    = buf_q;
              buf_full_d = 1'b0;
              state_d    = S_START;
              tx_d       = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.ready = ~buf_full_q;
  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE) | buf_full_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// tb/tb_uart_hamming_transmitter.sv - self-checking bench for uart_hamming_transmitter
module tb_uart_hamming_transmitter;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] code;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       tx;
  logic       busy;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;

  uart_hamming_transmitter_if bus_if ();

  uart_hamming_transmitter #(.OVERSAMPLE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus_if.slave),
    .tx        (tx),
    .busy      (busy),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level / state at cycle k (0..71) of a frame at OVERSAMPLE=8.
  function automatic logic exp_tx(input logic [6:0] code, input int k);
    int pos;
    pos = k / 8;
    if (pos == 0) return 1'b0;
    if (pos == 8) return 1'b1;
    return code[pos-1];
  endfunction

  function automatic logic [1:0] exp_st(input int k);
    int pos;
    pos = k / 8;
    if (pos == 0) return 2'b01;
    if (pos == 8) return 2'b11;
    return 2'b10;
  endfunction

  task automatic send(input logic [3:0] nib, input string name);
    check({name, "_ready_before"}, 32'(bus_if.ready), 32'd1);
    bus_if.data_in    = nib;
    bus_if.data_valid = 1'b1;
    step();
    bus_if.data_valid = 1'b0;
    check({name, "_ready_after"}, 32'(bus_if.ready), 32'd0);
  endtask

  // Samples one frame right after a send(), then the first idle cycle.
  task automatic run_frame(input logic [6:0] code, input string name, output logic [6:0] got);
    int bad_tx, bad_st, bad_busy;
    bad_tx = 0; bad_st = 0; bad_busy = 0;
    got = '0;
    for (int k = 0; k < 72; k++) begin
      step();
      if (tx !== exp_tx(code, k)) bad_tx++;
      if (state_out !== exp_st(k)) bad_st++;
      if (busy !== 1'b1) bad_busy++;
      if ((k % 8) == 4 && k >= 8 && k < 64) got[k/8-1] = tx;
    end
    check({name, "_tx_bad_cycles"}, 32'(bad_tx), 32'd0);
    check({name, "_state_bad_cycles"}, 32'(bad_st), 32'd0);
    check({name, "_busy_bad_cycles"}, 32'(bad_busy), 32'd0);
    check({name, "_code"}, 32'(got), 32'(code));
    step();
    check({name, "_idle_after"}, 32'({tx, bus_if.ready, busy, state_out}), 32'b11000);
  endtask

  vec_t vecs[16];

  initial begin
    logic [6:0] got;
    int bad, bad2;

    vecs[0]  = '{4'h0, 7'h00}; vecs[1]  = '{4'h1, 7'h07};
    vecs[2]  = '{4'h2, 7'h19}; vecs[3]  = '{4'h3, 7'h1E};
    vecs[4]  = '{4'h4, 7'h2A}; vecs[5]  = '{4'h5, 7'h2D};
    vecs[6]  = '{4'h6, 7'h33}; vecs[7]  = '{4'h7, 7'h34};
    vecs[8]  = '{4'h8, 7'h4B}; vecs[9]  = '{4'h9, 7'h4C};
    vecs[10] = '{4'hA, 7'h52}; vecs[11] = '{4'hB, 7'h55};
    vecs[12] = '{4'hC, 7'h61}; vecs[13] = '{4'hD, 7'h66};
    vecs[14] = '{4'hE, 7'h78}; vecs[15] = '{4'hF, 7'h7F};

    // Reset and idle line.
    rst = 1'b1; ena = 1'b1;
    bus_if.data_in = 4'h0; bus_if.data_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_outputs", 32'({tx, bus_if.ready, busy, state_out}), 32'b11000);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({tx, bus_if.ready, busy, state_out} !== 5'b11000) bad++;
    end
    check("idle_100_bad_cycles", 32'(bad), 32'd0);

    // Handshake frozen while ena is low.
    ena = 1'b0; bus_if.data_in = 4'hB; bus_if.data_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({tx, bus_if.ready, busy, state_out} !== 5'b11000) bad++;
    end
    check("ena_low_no_accept", 32'(bad), 32'd0);
    bus_if.data_valid = 1'b0; ena = 1'b1;
    step();

    // Single frame of 4'hB.
    send(4'hB, "s2");
    run_frame(7'h55, "s2", got);

    // All 16 nibbles; the received code bits must also decode back to the nibble.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].nib, $sformatf("vec%0d", i));
      run_frame(vecs[i].code, $sformatf("vec%0d", i), got);
      check($sformatf("vec%0d_decoded", i), 32'({got[6], got[5], got[4], got[2]}), 32'(vecs[i].nib));
    end

    // Back-to-back: 4'h0 then 4'h7 accepted mid-frame, no idle gap.
    send(4'h0, "s3a");
    bad = 0; bad2 = 0;
    for (int k = 0; k < 144; k++) begin
      if (k == 20) begin
        if (bus_if.ready !== 1'b1) bad2++;
        bus_if.data_in = 4'h7; bus_if.data_valid = 1'b1;
      end
      step();
      bus_if.data_valid = 1'b0;
      if (k < 72) begin
        if (tx !== exp_tx(7'h00, k) || state_out !== exp_st(k)) bad++;
      end else begin
        if (tx !== exp_tx(7'h34, k - 72) || state_out !== exp_st(k - 72)) bad++;
      end
      if (k >= 20 && k < 72 && bus_if.ready !== 1'b0) bad2++;
      if (k == 72) check("s3_ready_after_drain", 32'(bus_if.ready), 32'd1);
    end
    check("s3_wave_bad_cycles", 32'(bad), 32'd0);
    check("s3_ready_bad_cycles", 32'(bad2), 32'd0);
    step();
    check("s3_idle_after", 32'({tx, bus_if.ready, busy, state_out}), 32'b11000);

    // ena toggling: every bit is stretched to 16 clk.
    send(4'hB, "s5");
    bad = 0;
    for (int k = 0; k < 146; k++) begin
      ena = k[0];
      step();
      if (k == 0) begin
        check("s5_frozen_first", 32'({tx, bus_if.ready, state_out}), 32'b1000);
      end else if (k <= 144) begin
        if (tx !== exp_tx(7'h55, (k - 1) / 2) || state_out !== exp_st((k - 1) / 2)) bad++;
      end
    end
    check("s5_wave_bad_cycles", 32'(bad), 32'd0);
    check("s5_idle_after", 32'({tx, bus_if.ready, busy, state_out}), 32'b11000);
    ena = 1'b1;

    // Reset mid-frame with the buffer full.
    send(4'hB, "s6");
    for (int k = 0; k <= 30; k++) begin
      if (k == 10) begin
        bus_if.data_in = 4'h5; bus_if.data_valid = 1'b1;
      end
      if (k == 30) rst = 1'b1;
      step();
      bus_if.data_valid = 1'b0;
      if (k == 29) check("s6_busy_full_before_rst", 32'({busy, bus_if.ready, state_out}), 32'b1010);
    end
    check("s6_after_rst", 32'({tx, bus_if.ready, busy, state_out}), 32'b11000);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({tx, bus_if.ready, busy, state_out} !== 5'b11000) bad++;
    end
    check("s6_no_frame_after_rst", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
